// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver state encoding and a
// helper that sizes the internal counters.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Width needed to count 0..n-1, never less than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator; the divisor is picked up on every
// wrap, so a new i_div takes effect at the next reload.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= i_div;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchronises the serial line, deframes
// start/data/parity/stop and presents words through a one-entry valid/ready register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [DIV_W-1:0]     i_div,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = cnt_width(OVERSAMPLE);
  localparam int BW = cnt_width(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'(RX_IDLE);
  localparam logic [2:0] S_START  = 3'(RX_START);
  localparam logic [2:0] S_DATA   = 3'(RX_DATA);
  localparam logic [2:0] S_PARITY = 3'(RX_PARITY);
  localparam logic [2:0] S_STOP   = 3'(RX_STOP);

  localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD_BIT   = 1'(PARITY_ODD);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bitcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_ferr;
  logic                   r_perr;
  logic                   r_armed;

  logic w_tick;
  logic w_rxd;
  logic w_mid;
  logic w_wrap;
  logic w_ferr_final;
  logic w_deliver;

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_div (i_div),
    .o_tick(w_tick)
  );

  // Synchroniser resets to the idle level so reset release alone is no edge
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
    end
  end

  assign w_rxd        = r_sync[SYNC_STAGES-1];
  assign w_mid        = (r_cnt == CNT_MID);
  assign w_wrap       = (r_cnt == CNT_LAST);
  assign w_ferr_final = r_ferr | ~w_rxd;
  assign w_deliver    = w_tick && (r_state == S_STOP) && w_wrap && (r_bitcnt == STOP_LAST);
  assign o_busy       = (r_state != S_IDLE);

  // After a framing error (e.g. break) the line must return high before a new start counts
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_ferr   <= 1'b0;
      r_perr   <= 1'b0;
      r_armed  <= 1'b1;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_rxd) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_mid) begin
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_ferr   <= 1'b0;
            r_perr   <= 1'b0;
            r_state  <= w_rxd ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_wrap) begin
            r_cnt   <= '0;
            r_shift <= {w_rxd, r_shift[DATA_BITS-1:1]};
            if (r_bitcnt == BIT_LAST) begin
              r_bitcnt <= '0;
              r_state  <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_wrap) begin
            r_cnt   <= '0;
            r_perr  <= (((^r_shift) ^ w_rxd) != ODD_BIT);
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_wrap) begin
            r_cnt  <= '0;
            r_ferr <= w_ferr_final;
            if (r_bitcnt == STOP_LAST) begin
              r_bitcnt <= '0;
              r_armed  <= ~w_ferr_final;
              r_state  <= S_IDLE;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A word arriving while the previous one is still unclaimed is dropped, not merged
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (w_deliver) begin
        if (!o_valid || i_ready) begin
          o_data       <= r_shift;
          o_valid      <= 1'b1;
          o_frame_err  <= w_ferr_final;
          o_parity_err <= r_perr;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance for framing/handshake scenarios
// and an 8E1 instance for parity, both at 64 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] div = 16'd3;
  logic        rxd = 1'b1;
  logic        rxdP = 1'b1;
  logic        ready = 1'b1;
  logic        readyP = 1'b1;

  logic [7:0] data, dataP;
  logic       valid, ferr, perr, ovr, busy;
  logic       validP, ferrP, perrP, ovrP, busyP;

  int checks = 0;
  int errors = 0;

  int         validCycles, overrunCount, busyCycles;
  logic [7:0] capData;
  logic       capFerr, capPerr;
  int         validCyclesP, overrunCountP;
  logic [7:0] capDataP;
  logic       capFerrP, capPerrP;
  longint     ovTime = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(2)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_div(div), .i_rxd(rxd),
    .o_data(data), .o_valid(valid), .i_ready(ready),
    .o_frame_err(ferr), .o_parity_err(perr), .o_overrun(ovr), .o_busy(busy)
  );

  uart_rx #(
    .DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(2)
  ) dutP (
    .i_clk(clk), .i_rstn(rstn), .i_div(div), .i_rxd(rxdP),
    .o_data(dataP), .o_valid(validP), .i_ready(readyP),
    .o_frame_err(ferrP), .o_parity_err(perrP), .o_overrun(ovrP), .o_busy(busyP)
  );

  // Observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (valid) begin
      validCycles++;
      capData = data;
      capFerr = ferr;
      capPerr = perr;
    end
    if (ovr) begin
      overrunCount++;
      ovTime = $time;
    end
    if (busy) busyCycles++;
    if (validP) begin
      validCyclesP++;
      capDataP = dataP;
      capFerrP = ferrP;
      capPerrP = perrP;
    end
    if (ovrP) overrunCountP++;
  end

  task automatic clearMon();
    validCycles = 0; overrunCount = 0; busyCycles = 0;
    validCyclesP = 0; overrunCountP = 0;
    capData = 8'hxx; capFerr = 1'bx; capPerr = 1'bx;
    capDataP = 8'hxx; capFerrP = 1'bx; capPerrP = 1'bx;
  endtask

  task automatic driveBit(input int sel, input logic v);
    if (sel == 0) rxd = v; else rxdP = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // Start, 8 data LSB first, optional parity, stop, then one idle bit
  task automatic sendFrame(input int sel, input logic [7:0] d, input bit parEn,
                           input logic parBit, input logic stopVal);
    driveBit(sel, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(sel, d[i]);
    if (parEn) driveBit(sel, parBit);
    driveBit(sel, stopVal);
    driveBit(sel, 1'b1);
  endtask

  task automatic doReset();
    rstn = 1'b0; rxd = 1'b1; rxdP = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", ferr); end
    checks++; if (perr !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr: got %b expected 0", perr); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", ovr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk);
    #1 rstn = 1'b1;
    driveBit(0, 1'b1);
  endtask

  task automatic test_basic();
    ready = 1'b1;
    clearMon();
    sendFrame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    checks++; if (validCycles !== 1) begin errors++; $display("[TB] FAIL basic_valid_cycles: got %0d expected 1", validCycles); end
    checks++; if (capData !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data: got %h expected a5", capData); end
    checks++; if (capFerr !== 1'b0) begin errors++; $display("[TB] FAIL basic_ferr: got %b expected 0", capFerr); end
    checks++; if (capPerr !== 1'b0) begin errors++; $display("[TB] FAIL basic_perr: got %b expected 0", capPerr); end
  endtask

  task automatic test_glitch();
    clearMon();
    rxd = 1'b0;
    repeat (20) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++; if (busyCycles == 0) begin errors++; $display("[TB] FAIL glitch_start_seen: got busy cycles %0d expected nonzero", busyCycles); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy: got %b expected 0", busy); end
    checks++; if (validCycles !== 0) begin errors++; $display("[TB] FAIL glitch_valid: got %0d expected 0", validCycles); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame_error();
    clearMon();
    sendFrame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    checks++; if (capData !== 8'h3C) begin errors++; $display("[TB] FAIL ferr_data: got %h expected 3c", capData); end
    checks++; if (capFerr !== 1'b1) begin errors++; $display("[TB] FAIL ferr_flag: got %b expected 1", capFerr); end
    clearMon();
    sendFrame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    checks++; if (capData !== 8'h81) begin errors++; $display("[TB] FAIL ferr_next_data: got %h expected 81", capData); end
    checks++; if (capFerr !== 1'b0) begin errors++; $display("[TB] FAIL ferr_next_flag: got %b expected 0", capFerr); end
  endtask

  task automatic test_break();
    clearMon();
    rxd = 1'b0;
    repeat (12 * BIT_CLKS) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    checks++; if (validCycles !== 1) begin errors++; $display("[TB] FAIL break_frames: got %0d expected 1", validCycles); end
    checks++; if (capData !== 8'h00) begin errors++; $display("[TB] FAIL break_data: got %h expected 00", capData); end
    checks++; if (capFerr !== 1'b1) begin errors++; $display("[TB] FAIL break_ferr: got %b expected 1", capFerr); end
  endtask

  task automatic test_parity();
    readyP = 1'b1;
    clearMon();
    sendFrame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    checks++; if (validCyclesP !== 1) begin errors++; $display("[TB] FAIL parity_bad_frames: got %0d expected 1", validCyclesP); end
    checks++; if (capDataP !== 8'h07) begin errors++; $display("[TB] FAIL parity_bad_data: got %h expected 07", capDataP); end
    checks++; if (capPerrP !== 1'b1) begin errors++; $display("[TB] FAIL parity_bad_perr: got %b expected 1", capPerrP); end
    checks++; if (capFerrP !== 1'b0) begin errors++; $display("[TB] FAIL parity_bad_ferr: got %b expected 0", capFerrP); end
    clearMon();
    sendFrame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    checks++; if (capDataP !== 8'h07) begin errors++; $display("[TB] FAIL parity_good_data: got %h expected 07", capDataP); end
    checks++; if (capPerrP !== 1'b0) begin errors++; $display("[TB] FAIL parity_good_perr: got %b expected 0", capPerrP); end
    checks++; if (overrunCountP !== 0) begin errors++; $display("[TB] FAIL parity_overrun: got %0d expected 0", overrunCountP); end
    checks++; if (busyP !== 1'b0) begin errors++; $display("[TB] FAIL parity_busy_after: got %b expected 0", busyP); end
  endtask

  task automatic test_overrun();
    longint t0, t1, off;
    ready = 1'b0;
    doReset();
    t0 = $time;
    clearMon();
    sendFrame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    sendFrame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    checks++; if (overrunCount !== 1) begin errors++; $display("[TB] FAIL overrun_pulses: got %0d expected 1", overrunCount); end
    checks++; if (data !== 8'h11) begin errors++; $display("[TB] FAIL overrun_held_data: got %h expected 11", data); end
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL overrun_held_valid: got %b expected 1", valid); end
    // Replay from an identical reset so the second delivery lands on the same edge
    off = ovTime - 5 - t0;
    doReset();
    t1 = $time;
    clearMon();
    fork
      begin
        sendFrame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        sendFrame(0, 8'h22, 1'b0, 1'b0, 1'b1);
      end
      begin
        if (off > 9) begin
          #(off - 9);
          ready = 1'b1;
          #10;
          ready = 1'b0;
        end
      end
    join
    if (t1 < 0) $display("[TB] replay start time negative");
    checks++; if (data !== 8'h22) begin errors++; $display("[TB] FAIL handshake_data: got %h expected 22", data); end
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL handshake_valid: got %b expected 1", valid); end
    checks++; if (overrunCount !== 0) begin errors++; $display("[TB] FAIL handshake_overrun: got %0d expected 0", overrunCount); end
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid: got %b expected 0", valid); end
  endtask

  task automatic test_reset_midframe();
    ready = 1'b1;
    clearMon();
    driveBit(0, 1'b0);
    driveBit(0, 1'b0);
    driveBit(0, 1'b1);
    driveBit(0, 1'b0);
    rxd = 1'b1;
    repeat (32) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midframe_busy_before: got %b expected 1", busy); end
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midframe_rst_busy: got %b expected 0", busy); end
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL midframe_rst_data: got %h expected 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL midframe_rst_valid: got %b expected 0", valid); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("[TB] FAIL midframe_rst_overrun: got %b expected 0", ovr); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("[TB] FAIL midframe_rst_ferr: got %b expected 0", ferr); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    driveBit(0, 1'b1);
    clearMon();
    sendFrame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    checks++; if (validCycles !== 1) begin errors++; $display("[TB] FAIL midframe_resend_frames: got %0d expected 1", validCycles); end
    checks++; if (capData !== 8'h5A) begin errors++; $display("[TB] FAIL midframe_resend_data: got %h expected 5a", capData); end
    checks++; if (capFerr !== 1'b0) begin errors++; $display("[TB] FAIL midframe_resend_ferr: got %b expected 0", capFerr); end
  endtask

  initial begin
    clearMon();
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_break();
    test_parity();
    test_overrun();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
